// File: rtl/permutation_sequencer.sv
// rtl/permutation_sequencer.sv - round sequencer for the ASCON permutation datapath
//
// Purpose: turns one start request into a run of p^a or p^b rounds, driving
// the datapath input select, round index and state-register enable, and
// pulses done_o on the cycle the permuted state is valid at the datapath output.
//
// Ports:
//   clock_i   in   1  system clock, rising edge
//   reset_i   in   1  asynchronous active-high reset
//   start_i   in   1  request a permutation run
//   mode_i    in   1  0: p^a (ROUNDS_A rounds), 1: p^b (ROUNDS_B rounds)
//   abort_i   in   1  synchronous abort of a run in progress
//   select_o  out  1  1: datapath loads external state, 0: feedback
//   round_o   out  4  round index to constant addition (0..11)
//   enable_o  out  1  datapath state-register enable
//   busy_o    out  1  run in progress
//   done_o    out  1  one-cycle completion pulse

module permutation_sequencer #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       abort_i,
  output logic       select_o,
  output logic [3:0] round_o,
  output logic       enable_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd11;
  // A run of N rounds always ends on index 11, so it starts at 12-N.
  localparam logic [3:0] START_A    = 4'(12 - ROUNDS_A);
  localparam logic [3:0] START_B    = 4'(12 - ROUNDS_B);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_count;
  logic [3:0] w_count_next;
  logic [3:0] w_start_round;

  // The mode only matters at the accepting edge; the counter then encodes it.
  assign w_start_round = mode_i ? START_B : START_A;

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_next = S_FIRST;
          w_count_next = w_start_round;
        end
      end
      S_FIRST, S_RUN: begin
        // start_i is deliberately not looked at here: no queueing while busy.
        if (abort_i) begin
          w_state_next = S_IDLE;
          w_count_next = 4'd0;
        end else if (r_count == LAST_ROUND) begin
          // Counter stays at 11 so round_o keeps showing it in DONE.
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_RUN;
          w_count_next = r_count + 4'd1;
        end
      end
      S_DONE: begin
        // abort_i is ignored in DONE, so a coincident start always wins.
        if (start_i) begin
          w_state_next = S_FIRST;
          w_count_next = w_start_round;
        end else begin
          w_state_next = S_IDLE;
          w_count_next = 4'd0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_count_next = 4'd0;
      end
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    select_o = 1'b0;
    enable_o = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    round_o  = 4'd0;
    case (r_state)
      S_FIRST: begin
        select_o = 1'b1;
        enable_o = 1'b1;
        busy_o   = 1'b1;
        round_o  = r_count;
      end
      S_RUN: begin
        enable_o = 1'b1;
        busy_o   = 1'b1;
        round_o  = r_count;
      end
      S_DONE: begin
        done_o  = 1'b1;
        round_o = LAST_ROUND;
      end
      default: begin
        round_o = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_permutation_sequencer.sv
// tb/tb_permutation_sequencer.sv - directed bench for permutation_sequencer

module tb_permutation_sequencer;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic mode  = 1'b0;
  logic abort = 1'b0;

  logic       sel1, en1, busy1, done1;
  logic [3:0] round1;
  logic       sel2, en2, busy2, done2;
  logic [3:0] round2;
  logic [7:0] o1, o2;

  int total = 0;
  int bad   = 0;

  // Default parameters: p^a = 12 rounds, p^b = 6 rounds.
  permutation_sequencer dut (
    .clock_i (clk),
    .reset_i (rst),
    .start_i (start),
    .mode_i  (mode),
    .abort_i (abort),
    .select_o(sel1),
    .round_o (round1),
    .enable_o(en1),
    .busy_o  (busy1),
    .done_o  (done1)
  );

  // Boundary instance: 1-round p^a, 12-round p^b.
  permutation_sequencer #(.ROUNDS_A(1), .ROUNDS_B(12)) dut_edge (
    .clock_i (clk),
    .reset_i (rst),
    .start_i (start),
    .mode_i  (mode),
    .abort_i (abort),
    .select_o(sel2),
    .round_o (round2),
    .enable_o(en2),
    .busy_o  (busy2),
    .done_o  (done2)
  );

  assign o1 = {sel1, en1, busy1, done1, round1};
  assign o2 = {sel2, en2, busy2, done2, round2};

  always #5 clk = ~clk;

  function automatic logic [7:0] ev(input bit s, input bit e, input bit b,
                                    input bit d, input logic [3:0] r);
    return {s, e, b, d, r};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed={sel,en,busy,done,round}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Steps through RUN cycles with rounds first..last on the default instance.
  task automatic run_rounds(input string tag, input int first, input int last);
    for (int r = first; r <= last; r++) begin
      step();
      chk(tag, o1, ev(0, 1, 1, 0, 4'(r)));
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("reset_dut", o1, 8'h00);
    chk("reset_edge", o2, 8'h00);
    rst = 1'b0;

    // Test 1: p^a, 12 rounds; boundary instance runs a single round
    start = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    chk("t1_first", o1, ev(1, 1, 1, 0, 4'd0));
    chk("t1_edge_first", o2, ev(1, 1, 1, 0, 4'd11));
    for (int r = 1; r <= 11; r++) begin
      step();
      chk("t1_run", o1, ev(0, 1, 1, 0, 4'(r)));
      if (r == 1) chk("t1_edge_done", o2, ev(0, 0, 0, 1, 4'd11));
      if (r == 2) chk("t1_edge_idle", o2, 8'h00);
    end
    step();
    chk("t1_done", o1, ev(0, 0, 0, 1, 4'd11));
    step();
    chk("t1_idle", o1, 8'h00);

    // Test 2: p^b, 6 rounds; boundary instance runs 12 rounds
    start = 1'b1; mode = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= 13; i++) begin
      if (i < 6)       chk("t2_run", o1, ev(i == 0, 1, 1, 0, 4'(6 + i)));
      else if (i == 6) chk("t2_done", o1, ev(0, 0, 0, 1, 4'd11));
      else             chk("t2_idle", o1, 8'h00);
      if (i < 12)       chk("t2_edge_run", o2, ev(i == 0, 1, 1, 0, 4'(i)));
      else if (i == 12) chk("t2_edge_done", o2, ev(0, 0, 0, 1, 4'd11));
      else              chk("t2_edge_idle", o2, 8'h00);
      if (i < 13) step();
    end

    // Test 3: start held high; mode changes mid-run only take effect in DONE
    start = 1'b1; mode = 1'b0;
    step();
    chk("t3_first_a", o1, ev(1, 1, 1, 0, 4'd0));
    mode = 1'b1;
    run_rounds("t3_run_a", 1, 11);
    step();
    chk("t3_done_a", o1, ev(0, 0, 0, 1, 4'd11));
    step();
    chk("t3_first_b", o1, ev(1, 1, 1, 0, 4'd6));
    mode = 1'b0;
    run_rounds("t3_run_b", 7, 11);
    step();
    chk("t3_done_b", o1, ev(0, 0, 0, 1, 4'd11));
    start = 1'b0;
    step();
    chk("t3_idle", o1, 8'h00);

    // Test 4: abort at round 4, abort ignored in IDLE, start wins over abort in DONE
    start = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    chk("t4_first", o1, ev(1, 1, 1, 0, 4'd0));
    run_rounds("t4_run", 1, 4);
    abort = 1'b1;
    step();
    chk("t4_abort_idle", o1, 8'h00);
    abort = 1'b0;
    step();
    chk("t4_no_done", o1, 8'h00);
    abort = 1'b1; start = 1'b1;
    step();
    chk("t4_abort_ign_idle", o1, ev(1, 1, 1, 0, 4'd0));
    abort = 1'b0; start = 1'b0;
    run_rounds("t4_clean", 1, 11);
    step();
    chk("t4_done", o1, ev(0, 0, 0, 1, 4'd11));
    abort = 1'b1; start = 1'b1; mode = 1'b1;
    step();
    chk("t4_start_wins", o1, ev(1, 1, 1, 0, 4'd6));
    abort = 1'b0; start = 1'b0;
    run_rounds("t4_run_b", 7, 11);
    step();
    chk("t4_done_b", o1, ev(0, 0, 0, 1, 4'd11));
    step();
    chk("t4_idle", o1, 8'h00);

    // Test 5: asynchronous reset mid-run, then a p^b run as from power-up
    start = 1'b1; mode = 1'b0;
    step();
    start = 1'b0;
    run_rounds("t5_run", 1, 3);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_reset", o1, 8'h00);
    chk("t5_async_reset_edge", o2, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1; mode = 1'b1;
    step();
    start = 1'b0;
    chk("t5_first", o1, ev(1, 1, 1, 0, 4'd6));
    run_rounds("t5_run_b", 7, 11);
    step();
    chk("t5_done", o1, ev(0, 0, 0, 1, 4'd11));
    step();
    chk("t5_idle", o1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
